// File: rtl/n64_pkg.sv
// Shared definitions for the N64 controller one-wire engine.
package n64_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_BIT,
    S_TX_STOP,
    S_RX_WAIT_FALL,
    S_RX_SAMPLE,
    S_RX_WAIT_HIGH,
    S_DONE,
    S_ERR
  } n64_state_e;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_POLL   = 8'h01;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  // Bit-cell timing in units of one microsecond (U).
  localparam int LOW0   = 3;  // low time of a transmitted '0'
  localparam int LOW1   = 1;  // low time of a transmitted '1' (and stop bit)
  localparam int CELL   = 4;  // full bit cell
  localparam int SAMPLE = 2;  // sample point after a detected falling edge

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchronizer for the pad level plus a registered previous value
// for falling-edge detection. Resets to the idle-high line level.
module n64_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync_cur,
  output logic fall_pulse
);

  logic meta;
  logic prev;

  // Synchronize the raw pad and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 1'b1;
      sync_cur <= 1'b1;
      prev     <= 1'b1;
    end else begin
      meta     <= d;
      sync_cur <= meta;
      prev     <= sync_cur;
    end
  end

  assign fall_pulse = prev & ~sync_cur;

endmodule

// File: rtl/n64_poll_engine.sv
// N64 controller one-wire protocol engine: sends a command byte plus stop
// bit on an open-drain line, then captures the controller reply.
module n64_poll_engine
  import n64_pkg::*;
#(
  parameter int US_TICKS   = 100,  // must be at least 4
  parameter int RX_BITS    = 32,
  parameter int TIMEOUT_US = 64
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic        data_in,
  output logic        data_oe,
  output logic        busy,
  output logic [31:0] rx_data,
  output logic        done,
  output logic        err
);

  localparam int CELL_CYC = CELL * US_TICKS;
  localparam int TO_CYC   = TIMEOUT_US * US_TICKS;
  localparam int CNT_W    = $clog2(CELL_CYC);
  localparam int TO_W     = $clog2(TO_CYC + 1);
  localparam int BIT_W    = $clog2(RX_BITS + 1);

  localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(CELL_CYC - 1);
  localparam logic [CNT_W-1:0] U_LAST    = CNT_W'(LOW1 * US_TICKS - 1);
  localparam logic [CNT_W-1:0] SMP_LAST  = CNT_W'(SAMPLE * US_TICKS - 1);
  localparam logic [CNT_W-1:0] LOW0_CYC  = CNT_W'(LOW0 * US_TICKS);
  localparam logic [CNT_W-1:0] LOW1_CYC  = CNT_W'(LOW1 * US_TICKS);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(RX_BITS - 1);

  n64_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;        // position inside a cell / window
  logic [TO_W-1:0]  to_cnt, to_n;      // cycles spent in a wait state
  logic [2:0]       tx_idx, tx_idx_n;  // command bit being sent
  logic [BIT_W-1:0] bit_cnt, bit_n;    // response bits captured so far
  logic [31:0]      sr, sr_n;          // response shift register
  logic [7:0]       cmd_sr, cmd_n;     // command byte, MSB is current bit
  logic [31:0]      rx_n;
  logic             sync_cur;
  logic             fall_pulse;

  n64_line_sync u_sync (
    .clk        (PCLK),
    .rst        (PRESET),
    .d          (data_in),
    .sync_cur   (sync_cur),
    .fall_pulse (fall_pulse)
  );

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= S_IDLE;
    else        state <= state_n;
  end

  // Datapath registers: counters, shift registers and the result word.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt     <= '0;
      to_cnt  <= '0;
      tx_idx  <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      cmd_sr  <= '0;
      rx_data <= '0;
    end else begin
      cnt     <= cnt_n;
      to_cnt  <= to_n;
      tx_idx  <= tx_idx_n;
      bit_cnt <= bit_n;
      sr      <= sr_n;
      cmd_sr  <= cmd_n;
      rx_data <= rx_n;
    end
  end

  // Next-state, datapath updates and line/handshake outputs.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    to_n     = to_cnt;
    tx_idx_n = tx_idx;
    bit_n    = bit_cnt;
    sr_n     = sr;
    cmd_n    = cmd_sr;
    rx_n     = rx_data;
    data_oe  = 1'b0;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n  = S_TX_BIT;
          cmd_n    = cmd;
          cnt_n    = '0;
          to_n     = '0;
          tx_idx_n = '0;
          bit_n    = '0;
          sr_n     = '0;
        end
      end
      S_TX_BIT: begin
        data_oe = (cnt < (cmd_sr[7] ? LOW1_CYC : LOW0_CYC));
        if (cnt == CELL_LAST) begin
          cnt_n = '0;
          cmd_n = cmd_sr << 1;
          if (tx_idx == 3'd7) state_n = S_TX_STOP;
          else                tx_idx_n = tx_idx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_TX_STOP: begin
        data_oe = 1'b1;
        if (cnt == U_LAST) begin
          state_n = S_RX_WAIT_FALL;
          cnt_n   = '0;
          to_n    = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RX_WAIT_FALL: begin
        if (fall_pulse) begin
          state_n = S_RX_SAMPLE;
          cnt_n   = '0;
          to_n    = '0;
        end else if (to_cnt == TO_LAST) begin
          state_n = S_ERR;
        end else begin
          to_n = to_cnt + 1'b1;
        end
      end
      S_RX_SAMPLE: begin
        if (cnt == SMP_LAST) begin
          // Shifting in from a cleared register leaves short replies LSB-aligned.
          sr_n  = (sr << 1) | {31'b0, sync_cur};
          bit_n = bit_cnt + 1'b1;
          cnt_n = '0;
          to_n  = '0;
          if (bit_cnt == BIT_LAST) begin
            state_n = S_DONE;
            rx_n    = sr_n;
          end else begin
            state_n = S_RX_WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RX_WAIT_HIGH: begin
        if (sync_cur) begin
          state_n = S_RX_WAIT_FALL;
          to_n    = '0;
        end else if (to_cnt == TO_LAST) begin
          state_n = S_ERR;
        end else begin
          to_n = to_cnt + 1'b1;
        end
      end
      // The controller's own stop bit is not awaited; it falls while idle.
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_n64_poll_engine.sv
// Testbench for n64_poll_engine with U = 4 cycles; scoreboard of expected
// done/err responses checked by an independent monitor.
module tb_n64_poll_engine;
  import n64_pkg::*;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } resp_t;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic        data_in;
  logic        data_oe;
  logic        busy;
  logic [31:0] rx_data;
  logic        done;
  logic        err;
  logic        ctrl_low = 1'b0;

  int    nchk = 0;
  int    nerr = 0;
  int    cyc = 0;
  int    stuck_t = 0;
  resp_t sb[$];

  // Open-drain line: low when either side pulls.
  assign data_in = ~(data_oe === 1'b1 || ctrl_low);

  n64_poll_engine #(.US_TICKS(4), .RX_BITS(32), .TIMEOUT_US(64)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .cmd(cmd),
    .data_in(data_in), .data_oe(data_oe), .busy(busy),
    .rx_data(rx_data), .done(done), .err(err)
  );

  always #5 PCLK = ~PCLK;
  always @(negedge PCLK) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: every done/err pulse consumes one expected response.
  always @(negedge PCLK) begin
    if (!PRESET && (done === 1'b1 || err === 1'b1)) begin
      if (sb.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_resp got done=%b err=%b exp none", done, err);
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("resp_kind", {31'b0, err}, {31'b0, e.is_err});
        chk("resp_done", {31'b0, done}, {31'b0, !e.is_err});
        chk("resp_data", rx_data, e.data);
      end
    end
  end

  task automatic push(input bit is_err, input logic [31:0] d);
    resp_t e;
    e.is_err = is_err;
    e.data   = d;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [7:0] c);
    cmd = c; start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
  endtask

  // Record the command waveform; returns at the first released sample.
  task automatic capture_tx(input logic [7:0] c);
    logic [132:0] got, exp;
    int k, first;
    for (int w = 0; w < 20 && data_oe !== 1'b1; w++) @(negedge PCLK);
    k = 0;
    for (int b = 7; b >= 0; b--) begin
      for (int j = 0; j < 16; j++) begin
        exp[k] = (j < (c[b] ? 4 : 12));
        k++;
      end
    end
    for (int j = 0; j < 4; j++) exp[128 + j] = 1'b1;
    exp[132] = 1'b0;
    for (int i = 0; i <= 132; i++) begin
      got[i] = data_oe;
      if (i < 132) @(negedge PCLK);
    end
    first = -1;
    for (int i = 132; i >= 0; i--) if (got[i] !== exp[i]) first = i;
    nchk++;
    if (first >= 0) begin
      nerr++;
      $display("FAIL tx_wave cmd=%h first_diff=%0d got=%b exp=%b", c, first, got[first], exp[first]);
    end
  endtask

  // Controller model: nbits reply bits MSB first, then stop bit or stuck low.
  task automatic ctrl_reply(input logic [31:0] w, input int nbits, input bit stuck);
    repeat (6) @(negedge PCLK);
    for (int i = 0; i < nbits; i++) begin
      int low;
      low = w[31 - i] ? 4 : 12;
      ctrl_low = 1'b1;
      repeat (low) @(negedge PCLK);
      ctrl_low = 1'b0;
      repeat (16 - low) @(negedge PCLK);
    end
    ctrl_low = 1'b1;
    stuck_t = cyc;
    if (!stuck) begin
      repeat (4) @(negedge PCLK);
      ctrl_low = 1'b0;
    end
  endtask

  task automatic wait_resp(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge PCLK);
      if (done === 1'b1 || err === 1'b1) return;
    end
    nchk++; nerr++;
    $display("FAIL %s_timeout got no response exp done/err", name);
  endtask

  task automatic full_poll(input logic [31:0] w);
    push(1'b0, w);
    do_start(CMD_POLL);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    capture_tx(CMD_POLL);
    fork ctrl_reply(w, 32, 1'b0); join_none
    wait_resp("poll");
    @(negedge PCLK);
    chk("busy_after_done", {31'b0, busy}, 32'd0);
    repeat (30) @(negedge PCLK);
  endtask

  initial begin
    int gap;
    bit seen;
    // Reset state
    repeat (4) @(negedge PCLK);
    chk("rst_oe", {31'b0, data_oe}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rx", rx_data, 32'd0);
    PRESET = 1'b0;
    repeat (4) @(negedge PCLK);

    // Full poll
    full_poll(32'h8000_00FF);

    // No controller: timeout counted from the release of the line
    push(1'b1, 32'h8000_00FF);
    do_start(CMD_RESET);
    capture_tx(CMD_RESET);
    gap = 0;
    while (gap < 400 && err !== 1'b1) begin
      @(negedge PCLK);
      gap++;
    end
    chk("noctrl_gap", gap, 32'd256);
    chk("noctrl_oe", {31'b0, data_oe}, 32'd0);
    repeat (10) @(negedge PCLK);

    // Line stuck low after the 5th reply bit
    push(1'b1, 32'h8000_00FF);
    do_start(CMD_STATUS);
    capture_tx(CMD_STATUS);
    fork ctrl_reply(32'h8000_00FF, 5, 1'b1); join_none
    wait_resp("stuck");
    gap = cyc - stuck_t;
    chk("stuck_gap_ok", {31'b0, (gap >= 256 && gap <= 280)}, 32'd1);
    ctrl_low = 1'b0;
    repeat (20) @(negedge PCLK);
    full_poll(32'h1234_5678);

    // start during RX and in the same cycle as done are both ignored
    push(1'b0, 32'hA5A5_0F0F);
    do_start(CMD_POLL);
    capture_tx(CMD_POLL);
    fork ctrl_reply(32'hA5A5_0F0F, 32, 1'b0); join_none
    repeat (100) @(negedge PCLK);
    start = 1'b1; cmd = CMD_POLL;
    @(negedge PCLK);
    start = 1'b0;
    wait_resp("rx_start");
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    chk("busy_after_done2", {31'b0, busy}, 32'd0);
    seen = 1'b0;
    repeat (300) begin
      @(negedge PCLK);
      if (data_oe === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("no_restart", {31'b0, seen}, 32'd0);

    // Reset in the middle of transmit
    do_start(CMD_POLL);
    repeat (20) @(negedge PCLK);
    chk("pre_rst_oe", {31'b0, data_oe}, 32'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("midrst_oe", {31'b0, data_oe}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_rx", rx_data, 32'd0);
    PRESET = 1'b0;
    seen = 1'b0;
    repeat (300) begin
      @(negedge PCLK);
      if (data_oe === 1'b1) seen = 1'b1;
    end
    chk("midrst_quiet", {31'b0, seen}, 32'd0);
    full_poll(32'h0F0F_1234);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/n64_poll_engine.md
Name: n64_poll_engine

Overview:
- Cycle-accurate N64 controller one-wire protocol engine; sits directly downstream of the n64_magic_box APB slave, between its register file and the controller data pad.
- On a start pulse it transmits an 8-bit command plus stop bit, then receives the controller's reply (32 bits for poll).
- Returns the reply word with a valid pulse, or an error pulse on timeout.
- Line is open-drain: block only ever drives low, or releases.

Parameters:
- US_TICKS, 100, PCLK cycles per microsecond (FAB_CLK 100 MHz); minimum 4.
- RX_BITS, 32, response data bits captured (32 for poll 0x01, 24 for status 0x00).
- TIMEOUT_US, 64, max microseconds waiting for any controller falling edge.

Ports:
- PCLK  in  1  fabric clock, single clock domain.
- PRESET  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request from n64_magic_box; ignored while busy.
- cmd  in  8  command byte, latched on accepted start.
- data_in  in  1  raw pad level (asynchronous).
- data_oe  out  1  1 = pull line low, 0 = release (pad pulls high).
- busy  out  1  high from accepted start until done/err cycle inclusive.
- rx_data  out  32  last good response, MSB first, LSB-aligned when RX_BITS<32; held between transactions.
- done  out  1  one-cycle pulse, rx_data updated same cycle.
- err  out  1  one-cycle pulse on timeout; rx_data unchanged.

Behaviour:
- Reset (sync, PRESET=1 at PCLK edge): data_oe=0, busy=0, done=0, err=0, rx_data=0, state IDLE, all counters 0. Reset mid-transaction releases the line on that edge; no done/err is emitted.
- Timing unit U = US_TICKS cycles; bit cell = 4U.
- TX '0': data_oe=1 for 3U, 0 for 1U. TX '1': data_oe=1 for 1U, 0 for 3U. Command sent MSB first.
- TX stop: data_oe=1 for 1U, then release and enter RX_WAIT_FALL. Transmit length = 8*4U + 1U cycles from first data_oe assertion.
- data_in passes through a 2-flop synchronizer; a falling edge = sync_prev=1 and sync_cur=0 (2-cycle input latency).
- States:
  - IDLE: start=1 → latch cmd, busy=1, go TX_BIT (data_oe rises next cycle).
  - TX_BIT: after 8 cells → TX_STOP.
  - TX_STOP: after 1U → RX_WAIT_FALL.
  - RX_WAIT_FALL: falling edge → RX_SAMPLE and clear timeout counter; timeout counter reaches TIMEOUT_US*U → ERR.
  - RX_SAMPLE: wait 2U cycles after edge detect, shift sync_cur into the shift register. If bit count == RX_BITS → DONE, else RX_WAIT_HIGH.
  - RX_WAIT_HIGH: sync_cur=1 → RX_WAIT_FALL; line stuck low for TIMEOUT_US*U → ERR.
  - DONE: rx_data<=shift register, done=1, busy drops next cycle → IDLE. The controller's stop bit is not awaited.
  - ERR: err=1 for one cycle, data_oe=0 → IDLE.
- The timeout counter runs in both wait states; its width is sized for TIMEOUT_US*US_TICKS with no wrap.
- data_oe is 0 in every state other than the TX drive windows.
- start arriving in the same cycle as done/err is ignored; a new start is accepted only in IDLE.

Decomposition:
- Shared package n64_pkg:
  - state enum
  - CMD_STATUS=8'h00, CMD_POLL=8'h01, CMD_RESET=8'hFF
  - cell multipliers: LOW0=3, LOW1=1, CELL=4, SAMPLE=2
- One sub-module n64_line_sync: 2-flop synchronizer with registered previous value, exporting sync_cur and fall_pulse. Instantiated once; reset to 1 (line idle high).

Test Plan (US_TICKS=4, so U=4 cycles):
- Poll TX waveform: start with cmd=01 → data_oe pattern of seven cells of 12 low/4 high, then one cell of 4 low/12 high, then 4 low and release. Total 132 cycles from first assertion.
- Full poll: bench model replies 32'h8000_00FF plus stop bit → exactly one done pulse, rx_data=32'h8000_00FF, busy low the following cycle.
- No controller (line held high after stop) → err pulse exactly 256 cycles (64U) after release, rx_data keeps its previous value, data_oe=0.
- Line stuck low after the 5th response bit → err after 256 cycles in RX_WAIT_HIGH; next start proceeds normally.
- start pulsed during RX, and again in the same cycle as done → both ignored; exactly one transaction completes.
- PRESET asserted mid-TX while data_oe=1 → data_oe=0, busy=0 on the next edge; no done/err; a subsequent poll returns correct data.
